dnn_layer_fix: RTL and testbench

- Parametrised fixed-point fully-connected layer engine for the MNIST inference path.
- Computes N_OUT neurons as out[j] = sat(act(sum_i a[i]*W[j][i] + b[j]*BIAS_ONE) >>> FRAC_BITS).
- Reads activations and weights over a single synchronous memory read port.
- Adds selectable ReLU, saturation, and an argmax index. Instances chain into multi-layer networks with per-layer widths and depths.

---
 rtl/dnn_layer_fix_if.sv | 26 ++
 rtl/dnn_layer_fix.sv | 145 ++++++++++++++
 tb/tb_dnn_layer_fix.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dnn_layer_fix_if.sv
// Bundle between a dnn_layer_fix engine and its controller/memory: start and soft clear,
// the single synchronous read port, and the result/status outputs.
interface dnn_layer_fix_if #(
  parameter int DATA_WIDTH = 13,
  parameter int ADDR_WIDTH = 16,
  parameter int N_OUT      = 10
);
  localparam int IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  // start is a one-cycle request accepted only while busy=0 (IDLE or DONE); the engine
  // answers with busy for the whole run and then holds done=1 until the next start or reset.
  logic                         start;
  logic                         reset;
  logic signed [DATA_WIDTH-1:0] mem_data;
  logic [ADDR_WIDTH-1:0]        mem_addr;
  logic                         busy;
  logic                         done;
  logic signed [DATA_WIDTH-1:0] out [N_OUT];
  logic [IDX_W-1:0]             argmax;
  logic [2:0]                   dbg_state;

  modport master (output start, reset, mem_data,
                  input  mem_addr, busy, done, out, argmax, dbg_state);
  modport slave  (input  start, reset, mem_data,
                  output mem_addr, busy, done, out, argmax, dbg_state);
endinterface

// File: rtl/dnn_layer_fix.sv
// Fixed-point fully-connected layer: sequential MAC over one memory read port,
// then shift, saturate, optional ReLU and a running argmax per neuron.
module dnn_layer_fix #(
  parameter int                           DATA_WIDTH  = 13,
  parameter int                           ADDR_WIDTH  = 16,
  parameter int                           N_IN        = 784,
  parameter int                           N_OUT       = 10,
  parameter logic [ADDR_WIDTH-1:0]        ADDR_BASE_A = 16'h0000,
  parameter logic [ADDR_WIDTH-1:0]        ADDR_BASE_W = 16'h0310,
  parameter int                           FRAC_BITS   = 11,
  parameter logic signed [DATA_WIDTH-1:0] BIAS_ONE    = 13'b0100000000000,
  parameter bit                           RELU_EN     = 1'b1
) (
  input logic            clk,
  input logic            rst,
  dnn_layer_fix_if.slave bus
);
  localparam int ACC_W = 2 * DATA_WIDTH + $clog2(N_IN + 2);
  localparam int PW    = 2 * DATA_WIDTH;
  localparam int I_W   = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int J_W   = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam longint SAT_MAX_L = (longint'(1) <<< (DATA_WIDTH - 1)) - 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(SAT_MAX_L);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-SAT_MAX_L - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_FA = 3'd1, S_FW = 3'd2, S_FB = 3'd3,
    S_WB = 3'd4, S_ST = 3'd5, S_DONE = 3'd6
  } state_t;

  state_t                       state, state_nx;
  logic [I_W-1:0]               i_cnt;
  logic [J_W-1:0]               j_cnt;
  logic [ADDR_WIDTH-1:0]        row_base;
  logic signed [DATA_WIDTH-1:0] a_reg;
  logic signed [ACC_W-1:0]      acc;
  logic signed [DATA_WIDTH-1:0] out_r [N_OUT];
  logic signed [DATA_WIDTH-1:0] max_r;
  logic [J_W-1:0]               argmax_r;

  logic                         last_i, last_j;
  logic signed [PW-1:0]         mul_x, mul_y, prod;
  logic signed [ACC_W-1:0]      acc_add, shifted;
  logic signed [DATA_WIDTH-1:0] sat_v, result;

  assign last_i = (i_cnt == I_W'(N_IN - 1));
  assign last_j = (j_cnt == J_W'(N_OUT - 1));

  // The weight addressed in FW arrives during the following FA/FB cycle, so the
  // product a[i]*W[j][i] is accumulated there; WB adds the scaled bias.
  always_comb begin
    mul_x = {{DATA_WIDTH{a_reg[DATA_WIDTH-1]}}, a_reg};
    if (state == S_WB) mul_x = {{DATA_WIDTH{BIAS_ONE[DATA_WIDTH-1]}}, BIAS_ONE};
    mul_y   = {{DATA_WIDTH{bus.mem_data[DATA_WIDTH-1]}}, bus.mem_data};
    prod    = mul_x * mul_y;
    acc_add = acc + ACC_W'(prod);
  end

  always_comb begin
    shifted = acc >>> FRAC_BITS;
    if (shifted > SAT_MAX)      sat_v = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else if (shifted < SAT_MIN) sat_v = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else                        sat_v = shifted[DATA_WIDTH-1:0];
    result = (RELU_EN && sat_v[DATA_WIDTH-1]) ? '0 : sat_v;
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            state <= S_IDLE;
    else if (bus.reset) state <= S_IDLE;
    else                state <= state_nx;
  end

  // FSM: next state
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE: if (bus.start) state_nx = S_FA;
      S_FA:           state_nx = S_FW;
      S_FW:           state_nx = last_i ? S_FB : S_FA;
      S_FB:           state_nx = S_WB;
      S_WB:           state_nx = S_ST;
      S_ST:           state_nx = last_j ? S_DONE : S_FA;
      default:        state_nx = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    bus.busy     = 1'b1;
    bus.done     = 1'b0;
    bus.mem_addr = '0;
    case (state)
      S_IDLE:  bus.busy = 1'b0;
      S_DONE:  begin bus.busy = 1'b0; bus.done = 1'b1; end
      S_FA:    bus.mem_addr = ADDR_BASE_A + ADDR_WIDTH'(i_cnt);
      S_FW:    bus.mem_addr = row_base + ADDR_WIDTH'(i_cnt);
      S_FB:    bus.mem_addr = row_base + ADDR_WIDTH'(N_IN);
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_cnt <= '0; j_cnt <= '0; row_base <= '0; a_reg <= '0; acc <= '0;
      max_r <= '0; argmax_r <= '0;
      for (int k = 0; k < N_OUT; k++) out_r[k] <= '0;
    end else if (bus.reset) begin
      i_cnt <= '0; j_cnt <= '0; row_base <= '0; a_reg <= '0; acc <= '0;
      max_r <= '0; argmax_r <= '0;
      for (int k = 0; k < N_OUT; k++) out_r[k] <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (bus.start) begin
          i_cnt <= '0; j_cnt <= '0; acc <= '0; row_base <= ADDR_BASE_W;
        end
        S_FA: if (i_cnt != '0) acc <= acc_add;
        S_FW: begin
          a_reg <= bus.mem_data;
          if (!last_i) i_cnt <= i_cnt + 1'b1;
        end
        S_FB, S_WB: acc <= acc_add;
        S_ST: begin
          out_r[j_cnt] <= result;
          // Strict compare keeps the lowest index on ties; neuron 0 seeds the max.
          if (j_cnt == '0 || result > max_r) begin
            max_r    <= result;
            argmax_r <= j_cnt;
          end
          acc   <= '0;
          i_cnt <= '0;
          if (!last_j) begin
            j_cnt    <= j_cnt + 1'b1;
            row_base <= row_base + ADDR_WIDTH'(N_IN + 1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.out       = out_r;
  assign bus.argmax    = argmax_r;
  assign bus.dbg_state = state;
endmodule

// File: tb/tb_dnn_layer_fix.sv
// Bench for dnn_layer_fix with N_IN=4, N_OUT=3: a ReLU and a linear instance share one
// memory image; a reference model fills exp_q and each scenario task compares results.
module tb_dnn_layer_fix;
  localparam int DW = 13;
  localparam int NI = 4;
  localparam int NO = 3;
  localparam int WB = 16'h0310;
  localparam int BUSY_CYC = NO * (2 * NI + 3);

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic soft_reset;
  logic [DW-1:0] mem [0:1023];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] obs [8];
  int checks = 0;
  int errors = 0;

  dnn_layer_fix_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(16), .N_OUT(NO)) bus_r ();
  dnn_layer_fix_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(16), .N_OUT(NO)) bus_l ();

  dnn_layer_fix #(.N_IN(NI), .N_OUT(NO), .RELU_EN(1'b1)) u_relu (.clk(clk), .rst(rst), .bus(bus_r));
  dnn_layer_fix #(.N_IN(NI), .N_OUT(NO), .RELU_EN(1'b0)) u_lin  (.clk(clk), .rst(rst), .bus(bus_l));

  assign bus_r.start = start;
  assign bus_l.start = start;
  assign bus_r.reset = soft_reset;
  assign bus_l.reset = soft_reset;

  // clock / reset / memory model (one cycle read latency)
  always #5 clk = ~clk;

  always @(posedge clk) begin
    bus_r.mem_data <= mem[bus_r.mem_addr[9:0]];
    bus_l.mem_data <= mem[bus_l.mem_addr[9:0]];
  end

  // ---------------- driver tasks ----------------
  task automatic clear_mem();
    for (int k = 0; k < 1024; k++) mem[k] = '0;
  endtask

  task automatic load_a(input int a0, input int a1, input int a2, input int a3);
    mem[0] = DW'(a0); mem[1] = DW'(a1); mem[2] = DW'(a2); mem[3] = DW'(a3);
  endtask

  task automatic load_row(input int j, input int w0, input int w1, input int w2,
                          input int w3, input int b);
    mem[WB + j*5 + 0] = DW'(w0); mem[WB + j*5 + 1] = DW'(w1);
    mem[WB + j*5 + 2] = DW'(w2); mem[WB + j*5 + 3] = DW'(w3);
    mem[WB + j*5 + 4] = DW'(b);
  endtask

  function automatic longint sx(input logic [DW-1:0] v);
    return longint'($signed(v));
  endfunction

  // Reference model: push out[0..2], argmax for the ReLU instance, then the linear one.
  task automatic push_expected();
    for (int r = 1; r >= 0; r--) begin
      longint mx;
      int am;
      mx = 0; am = 0;
      for (int j = 0; j < NO; j++) begin
        longint acc, v;
        acc = 0;
        for (int i = 0; i < NI; i++) acc += sx(mem[i]) * sx(mem[WB + j*5 + i]);
        acc += sx(mem[WB + j*5 + 4]) * 2048;
        v = acc >>> 11;
        if (v > 4095) v = 4095;
        if (v < -4096) v = -4096;
        if (r == 1 && v < 0) v = 0;
        exp_q.push_back(DW'(v));
        if (j == 0 || v > mx) begin mx = v; am = j; end
      end
      exp_q.push_back(DW'(am));
    end
  endtask

  task automatic snapshot();
    for (int k = 0; k < NO; k++) begin
      obs[k]      = bus_r.out[k];
      obs[k + 4]  = bus_l.out[k];
    end
    obs[3] = DW'(bus_r.argmax);
    obs[7] = DW'(bus_l.argmax);
  endtask

  // Pulses start, optionally pulses it again pulse_at cycles into the run, waits for done.
  task automatic run_layer(input int pulse_at, output int busy_cyc, output bit ok,
                           output logic done_after_start);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    done_after_start = bus_r.done;
    busy_cyc = 0;
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (bus_r.done && bus_l.done) begin ok = 1'b1; break; end
      if (bus_r.busy) busy_cyc++;
      start = (c == pulse_at);
      @(negedge clk);
    end
    start = 1'b0;
    snapshot();
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    checks++;
    if (bus_r.busy !== 1'b0 || bus_r.done !== 1'b0 || bus_r.mem_addr !== 16'h0 ||
        bus_r.dbg_state !== 3'd0 || bus_r.argmax !== 2'd0) begin
      errors++;
      $display("FAIL reset_status busy=%b done=%b addr=%h state=%0d argmax=%0d required 0",
               bus_r.busy, bus_r.done, bus_r.mem_addr, bus_r.dbg_state, bus_r.argmax);
    end
    for (int k = 0; k < NO; k++) begin
      checks++;
      if (bus_r.out[k] !== 13'd0 || bus_l.out[k] !== 13'd0) begin
        errors++;
        $display("FAIL reset_out[%0d] got %0d/%0d required 0", k, bus_r.out[k], bus_l.out[k]);
      end
    end
  endtask

  task automatic test_identity();
    int bc; bit ok; logic dal; logic [DW-1:0] e;
    clear_mem();
    load_a(2048, 0, 0, 0);
    load_row(0, 2048, 0, 0, 0, 0);
    load_row(1, 0, 2048, 0, 0, 1024);
    load_row(2, 0, 0, 0, 0, 0);
    push_expected();
    run_layer(-1, bc, ok, dal);
    checks++;
    if (!ok || bc !== BUSY_CYC) begin
      errors++; $display("FAIL identity_latency done=%b busy_cycles=%0d required %0d", ok, bc, BUSY_CYC);
    end
    for (int k = 0; k < 8; k++) begin
      e = exp_q.pop_front(); checks++;
      if (obs[k] !== e) begin errors++; $display("FAIL identity slot%0d got %0d required %0d", k, $signed(obs[k]), $signed(e)); end
    end
    checks++;
    if (bus_r.out[0] !== 13'd2048 || bus_r.out[1] !== 13'd1024 || bus_r.out[2] !== 13'd0) begin
      errors++; $display("FAIL identity_const got %0d,%0d,%0d required 2048,1024,0", bus_r.out[0], bus_r.out[1], bus_r.out[2]);
    end
  endtask

  task automatic test_saturation();
    int bc; bit ok; logic dal; logic [DW-1:0] e;
    for (int s = 0; s < 2; s++) begin
      int w;
      w = (s == 0) ? 4095 : -4096;
      clear_mem();
      load_a(4095, 4095, 4095, 4095);
      load_row(0, w, w, w, w, w);
      push_expected();
      run_layer(-1, bc, ok, dal);
      checks++;
      if (!ok) begin errors++; $display("FAIL saturation%0d_timeout", s); end
      for (int k = 0; k < 8; k++) begin
        e = exp_q.pop_front(); checks++;
        if (obs[k] !== e) begin errors++; $display("FAIL saturation%0d slot%0d got %0d required %0d", s, k, $signed(obs[k]), $signed(e)); end
      end
    end
    checks++;
    if (bus_l.out[0] !== 13'h1000) begin
      errors++; $display("FAIL saturation_neg got %0d required -4096", $signed(bus_l.out[0]));
    end
  endtask

  task automatic test_relu();
    int bc; bit ok; logic dal; logic [DW-1:0] e;
    clear_mem();
    load_a(2048, 0, 0, 0);
    load_row(0, -2048, 0, 0, 0, 0);
    load_row(1, 0, 0, 0, 0, -1);
    push_expected();
    run_layer(-1, bc, ok, dal);
    checks++;
    if (!ok) begin errors++; $display("FAIL relu_timeout"); end
    for (int k = 0; k < 8; k++) begin
      e = exp_q.pop_front(); checks++;
      if (obs[k] !== e) begin errors++; $display("FAIL relu slot%0d got %0d required %0d", k, $signed(obs[k]), $signed(e)); end
    end
    checks++;
    if (bus_r.out[0] !== 13'd0 || bus_l.out[0] !== 13'h1800) begin
      errors++; $display("FAIL relu_const got %h/%h required 0000/1800", bus_r.out[0], bus_l.out[0]);
    end
  endtask

  task automatic test_argmax_tie();
    int bc; bit ok; logic dal; logic [DW-1:0] e;
    for (int s = 0; s < 2; s++) begin
      clear_mem();
      load_a(2048, 0, 0, 0);
      load_row(0, (s == 0) ? 100 : -5, 0, 0, 0, 0);
      load_row(1, (s == 0) ? 300 : -3, 0, 0, 0, 0);
      load_row(2, (s == 0) ? 300 : -3, 0, 0, 0, 0);
      push_expected();
      run_layer(-1, bc, ok, dal);
      checks++;
      if (!ok) begin errors++; $display("FAIL argmax%0d_timeout", s); end
      for (int k = 0; k < 8; k++) begin
        e = exp_q.pop_front(); checks++;
        if (obs[k] !== e) begin errors++; $display("FAIL argmax%0d slot%0d got %0d required %0d", s, k, $signed(obs[k]), $signed(e)); end
      end
      checks++;
      if (bus_l.argmax !== 2'd1) begin errors++; $display("FAIL argmax%0d_lin got %0d required 1", s, bus_l.argmax); end
    end
  endtask

  task automatic test_random();
    int bc; bit ok; logic dal; logic [DW-1:0] e;
    for (int s = 0; s < 4; s++) begin
      clear_mem();
      for (int i = 0; i < NI; i++) mem[i] = DW'($urandom_range(0, 8191));
      for (int j = 0; j < NO; j++)
        for (int i = 0; i < 5; i++) mem[WB + j*5 + i] = DW'($urandom_range(0, 8191));
      if (s == 0) begin load_a(1, 0, 0, 0); load_row(0, -1, 0, 0, 0, 0); end
      push_expected();
      run_layer(-1, bc, ok, dal);
      checks++;
      if (!ok || bc !== BUSY_CYC) begin errors++; $display("FAIL random%0d_latency busy_cycles=%0d required %0d", s, bc, BUSY_CYC); end
      for (int k = 0; k < 8; k++) begin
        e = exp_q.pop_front(); checks++;
        if (obs[k] !== e) begin errors++; $display("FAIL random%0d slot%0d got %0d required %0d", s, k, $signed(obs[k]), $signed(e)); end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int bc; bit ok; logic dal; logic [DW-1:0] e;
    for (int s = 0; s < 2; s++) begin
      clear_mem();
      load_a(2048, 0, 0, 0);
      load_row(0, 2048, 0, 0, 0, 0);
      load_row(1, 0, 2048, 0, 0, 1024);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (12) @(negedge clk);
      checks++;
      if (bus_r.dbg_state !== 3'd2 || bus_r.out[0] !== 13'd2048) begin
        errors++; $display("FAIL midrun%0d_pre state=%0d out0=%0d required FW(2) and 2048", s, bus_r.dbg_state, bus_r.out[0]);
      end
      if (s == 0) begin
        #2 rst = 1'b1;
        #1;
      end else begin
        soft_reset = 1'b1;
        #1;
        checks++;
        if (bus_r.busy !== 1'b1) begin errors++; $display("FAIL midrun_sync_early busy=%b required 1", bus_r.busy); end
        @(negedge clk);
      end
      checks++;
      if (bus_r.out[0] !== 13'd0 || bus_l.out[0] !== 13'd0 || bus_r.busy !== 1'b0 ||
          bus_r.done !== 1'b0 || bus_r.mem_addr !== 16'h0 || bus_l.mem_addr !== 16'h0) begin
        errors++;
        $display("FAIL midrun%0d_clear out0=%0d busy=%b done=%b addr=%h required all 0",
                 s, bus_r.out[0], bus_r.busy, bus_r.done, bus_r.mem_addr);
      end
      @(negedge clk);
      rst = 1'b0; soft_reset = 1'b0;
      push_expected();
      run_layer(-1, bc, ok, dal);
      checks++;
      if (!ok || bc !== BUSY_CYC) begin errors++; $display("FAIL midrun%0d_rerun busy_cycles=%0d required %0d", s, bc, BUSY_CYC); end
      for (int k = 0; k < 8; k++) begin
        e = exp_q.pop_front(); checks++;
        if (obs[k] !== e) begin errors++; $display("FAIL midrun%0d slot%0d got %0d required %0d", s, k, $signed(obs[k]), $signed(e)); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int bc; bit ok; logic dal; logic [DW-1:0] e;
    clear_mem();
    load_a(1000, -700, 300, 2047);
    load_row(0, 500, 500, -500, 100, 7);
    load_row(1, -900, 20, 1500, 2000, -300);
    load_row(2, 4000, -4000, 1, -1, 512);
    for (int s = 0; s < 2; s++) begin
      push_expected();
      run_layer((s == 0) ? 5 : -1, bc, ok, dal);
      checks++;
      if (!ok || bc !== BUSY_CYC || dal !== 1'b0) begin
        errors++; $display("FAIL handshake%0d busy_cycles=%0d done_after_start=%b required %0d and 0", s, bc, dal, BUSY_CYC);
      end
      for (int k = 0; k < 8; k++) begin
        e = exp_q.pop_front(); checks++;
        if (obs[k] !== e) begin errors++; $display("FAIL handshake%0d slot%0d got %0d required %0d", s, k, $signed(obs[k]), $signed(e)); end
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; soft_reset = 1'b0;
    clear_mem();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_identity();
    test_saturation();
    test_relu();
    test_argmax_tie();
    test_random();
    test_reset_mid_run();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover %0d entries required 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
